// File: rtl/vga_pixel_capture.sv
// Decimating pixel-stream capture from the VGA output into a FWFT FIFO with
// valid/ready drain, frame/line start markers and overflow accounting.
module vga_pixel_capture #(
  parameter int COLOR_W         = 8,
  parameter int DECIM           = 4,
  parameter int FIFO_DEPTH      = 16,
  parameter bit SYNC_ACTIVE_LOW = 1'b1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic                          clr_status,
  input  logic                          visible,
  input  logic                          h_sync,
  input  logic                          v_sync,
  input  logic [COLOR_W-1:0]            red,
  input  logic [COLOR_W-1:0]            green,
  input  logic [COLOR_W-1:0]            blue,
  input  logic                          out_ready,
  output logic                          out_valid,
  output logic [3*COLOR_W+1:0]          out_data,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  output logic [15:0]                   dropped_count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int DW = 3*COLOR_W + 2;
  localparam logic [7:0]  LAST     = 8'(DECIM - 1);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(FIFO_DEPTH);

  logic          vs_prev, vis_prev, sof_pend, sol_pend;
  logic [7:0]    dcnt;
  logic [DW-1:0] mem [FIFO_DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr;

  logic          vs_act, hs_act, vs_rise, vis_rise, sof_eff, sol_eff;
  logic          take, fire, full, empty, push, pop, drop;
  logic [7:0]    cnt_eff;
  logic [DW-1:0] word;
  logic          unused_hs;

  assign vs_act    = v_sync ^ SYNC_ACTIVE_LOW;
  assign hs_act    = h_sync ^ SYNC_ACTIVE_LOW;
  // Line starts are taken from visible, so the normalised hsync has no consumer.
  assign unused_hs = hs_act;

  // Edges seen this cycle take effect on a sample fired in the same cycle.
  assign vs_rise  = vs_act & ~vs_prev;
  assign vis_rise = visible & ~vis_prev;
  assign cnt_eff  = vs_rise ? 8'd0 : dcnt;
  assign sof_eff  = sof_pend | vs_rise;
  assign sol_eff  = sol_pend | vis_rise;
  assign take     = enable & visible;
  assign fire     = take && (cnt_eff == LAST);
  assign word     = {sof_eff, sol_eff, red, green, blue};

  assign fifo_level = wr_ptr - rd_ptr;
  assign full       = (fifo_level == FULL_LVL);
  assign empty      = (fifo_level == '0);
  assign out_valid  = ~empty;
  assign out_data   = empty ? '0 : mem[rd_ptr[AW-1:0]];
  assign pop        = out_valid & out_ready;
  assign push       = fire & (~full | pop);
  assign drop       = fire & full & ~pop;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vs_prev  <= 1'b0;
      vis_prev <= 1'b0;
      dcnt     <= '0;
      sof_pend <= 1'b0;
      sol_pend <= 1'b0;
    end else begin
      vs_prev  <= vs_act;
      vis_prev <= visible;
      if (!enable) begin
        dcnt     <= '0;
        sof_pend <= 1'b0;
        sol_pend <= 1'b0;
      end else begin
        dcnt     <= fire ? 8'd0 : (take ? cnt_eff + 8'd1 : cnt_eff);
        sof_pend <= fire ? 1'b0 : sof_eff;
        sol_pend <= fire ? 1'b0 : sol_eff;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: out_data is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= word;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow      <= 1'b0;
      dropped_count <= '0;
    end else if (drop) begin
      overflow      <= 1'b1;
      dropped_count <= clr_status ? 16'd1 :
                       (dropped_count == 16'hFFFF) ? dropped_count : dropped_count + 16'd1;
    end else if (clr_status) begin
      overflow      <= 1'b0;
      dropped_count <= '0;
    end
  end
endmodule
